// File: rtl/regfile_debug_master.sv
// Debug host port that stalls the core and reads, writes, bit-sets or bit-clears one register file entry.
// Optional HOLD timeout enabled by defining DBG_TIMEOUT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module regfile_debug_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmdValid,
  output logic                   cmdReady,
  input  logic [1:0]             cmdOp,
  input  logic [4:0]             cmdAddr,
  input  logic [`DATA_WIDTH-1:0] cmdData,
  output logic                   rspValid,
  input  logic                   rspReady,
  output logic [`DATA_WIDTH-1:0] rspData,
  output logic                   rspErr,
  output logic                   holdReq,
  input  logic                   holdAck,
  output logic [2:0]             writeCommand,
  output logic [4:0]             fileAddr,
  output logic [`DATA_WIDTH-1:0] writeData,
  input  logic [`DATA_WIDTH-1:0] regfileIn
);

  typedef enum logic [2:0] {IDLE, HOLD, READ, WRITE, RESP} state_t;

`ifdef DBG_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [4:0]             addr_q, addr_d;
  logic [`DATA_WIDTH-1:0] data_q, data_d;
  logic [`DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [`DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [7:0]             cnt_q, cnt_d;

  logic [`DATA_WIDTH-1:0] bit_mask;
  logic [`DATA_WIDTH-1:0] wr_value;
  logic                   timeout_hit;

  assign bit_mask    = `DATA_WIDTH'(1) << data_q[2:0];
  assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    case (op_q)
      2'b10:   wr_value = rdata_q | bit_mask;
      2'b11:   wr_value = rdata_q & ~bit_mask;
      default: wr_value = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      addr_q     <= 5'd0;
      data_q     <= '0;
      rdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = 8'd0;
    cmdReady     = 1'b0;
    rspValid     = 1'b0;
    holdReq      = 1'b0;
    writeCommand = 3'b000;
    fileAddr     = 5'd0;
    writeData    = '0;

    case (state_q)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          op_d      = cmdOp;
          addr_d    = cmdAddr;
          data_d    = cmdData;
          rsp_err_d = 1'b0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        holdReq = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (holdAck) begin
          cnt_d   = 8'd0;
          state_d = (op_q == 2'b01) ? WRITE : READ;
        end else if (timeout_hit) begin
          cnt_d      = 8'd0;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end
      end
      READ: begin
        holdReq  = 1'b1;
        fileAddr = addr_q;
        if (!holdAck) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          rdata_d = regfileIn;
          if (op_q == 2'b00) begin
            rsp_data_d = regfileIn;
            state_d    = RESP;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        holdReq   = 1'b1;
        fileAddr  = addr_q;
        writeData = wr_value;
        state_d   = RESP;
        // A core that resumes mid-access must never see a write land.
        if (holdAck) begin
          writeCommand = 3'b010;
          rsp_data_d   = wr_value;
        end else begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end
      end
      RESP: begin
        rspValid = 1'b1;
        if (rspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rspData = rsp_data_q;
  assign rspErr  = rsp_err_q;

endmodule
